// File: rtl/mc_core_param.sv
// mc_core_param: parametrised multi-cycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB/HALT) with req/ready memory port.
// Optional: define MC_CORE_OVF_TRAP_EN to halt with exc_code 3 on signed overflow of add/sub/addi.
module mc_core_param #(
  parameter int                ADDR_W   = 32,
  parameter int                NUM_REGS = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [2:0]        state_out,
  output logic              halted,
  output logic [1:0]        exc_code
);
  localparam int RW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    EXC_NONE = 2'd0, EXC_ILLEGAL = 2'd1, EXC_ALIGN = 2'd2, EXC_OVF = 2'd3
  } exc_t;

  typedef struct packed {
    logic r_alu;
    logic brk;
    logic addi;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic legal;
  } dec_t;

  state_t            state, state_nxt;
  exc_t              exc, exc_nxt;
  logic              started;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir, a, b, alu_out, mdr;
  logic [31:0]       rf [NUM_REGS];
  dec_t              dec;

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd;
  logic [RW-1:0]     rs_idx, rt_idx, wb_idx;
  logic [31:0]       simm, pc32, br_tgt, jt32, wb_data;
  logic [31:0]       opb, sum, diff, alu_res;
  logic              mem_accept, misalign, ovf_trap;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign rs_idx = rs[RW-1:0];
  assign rt_idx = rt[RW-1:0];
  assign simm   = {{16{ir[15]}}, ir[15:0]};
  assign pc32   = 32'(pc);
  assign br_tgt = pc32 + {simm[29:0], 2'b00};
  assign jt32   = {pc32[31:28], ir[25:0], 2'b00};

  always_comb begin
    dec      = '0;
    dec.addi = (op == 6'h08);
    dec.lw   = (op == 6'h23);
    dec.sw   = (op == 6'h2B);
    dec.beq  = (op == 6'h04);
    dec.j    = (op == 6'h02);
    if (op == 6'h00) begin
      case (funct)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: dec.r_alu = 1'b1;
        6'h0D:                             dec.brk   = 1'b1;
        default: ;
      endcase
    end
    dec.legal = dec.r_alu | dec.brk | dec.addi | dec.lw | dec.sw | dec.beq | dec.j;
  end

  // Operand B is the register for R-type, the sign-extended immediate for addi/lw/sw.
  assign opb  = dec.r_alu ? b : simm;
  assign sum  = a + opb;
  assign diff = a - b;

  always_comb begin
    alu_res = sum;
    if (dec.r_alu) begin
      case (funct)
        6'h22:   alu_res = diff;
        6'h24:   alu_res = a & b;
        6'h25:   alu_res = a | b;
        6'h2A:   alu_res = {31'd0, $signed(a) < $signed(b)};
        default: alu_res = sum;
      endcase
    end
  end

  assign misalign = (dec.lw || dec.sw) && (sum[1:0] != 2'b00);

`ifdef MC_CORE_OVF_TRAP_EN
  logic add_ovf, sub_ovf;
  assign add_ovf  = (a[31] == opb[31]) && (sum[31] != a[31]);
  assign sub_ovf  = (a[31] != b[31]) && (diff[31] != a[31]);
  assign ovf_trap = ((dec.addi || (dec.r_alu && funct == 6'h20)) && add_ovf) ||
                    (dec.r_alu && funct == 6'h22 && sub_ovf);
`else
  assign ovf_trap = 1'b0;
`endif

  // started holds off the first request until the first edge after reset release,
  // and clears asynchronously so a pending request is dropped at once.
  assign mem_req    = started && (state == S_FETCH || state == S_MEM);
  assign mem_we     = (state == S_MEM) && dec.sw;
  assign mem_addr   = (state == S_MEM) ? alu_out[ADDR_W-1:0] : pc;
  assign mem_wdata  = b;
  assign mem_accept = mem_req && mem_ready;

  assign pc_out    = pc;
  assign state_out = state;
  assign halted    = (state == S_HALT);
  assign exc_code  = exc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      exc     <= EXC_NONE;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      exc     <= exc_nxt;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    exc_nxt   = exc;
    case (state)
      S_FETCH:  if (mem_accept) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!dec.legal) begin
          state_nxt = S_HALT;
          exc_nxt   = EXC_ILLEGAL;
        end else if (dec.brk) state_nxt = S_HALT;
        else if (dec.j)       state_nxt = S_FETCH;
        else                  state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (misalign) begin
          state_nxt = S_HALT;
          exc_nxt   = EXC_ALIGN;
        end else if (dec.lw || dec.sw) state_nxt = S_MEM;
        else if (dec.beq)              state_nxt = S_FETCH;
        else if (ovf_trap) begin
          state_nxt = S_HALT;
          exc_nxt   = EXC_OVF;
        end else state_nxt = S_WB;
      end
      S_MEM:    if (mem_accept) state_nxt = dec.sw ? S_FETCH : S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_accept) begin
          ir <= mem_rdata;
          pc <= pc + ADDR_W'(4);
        end
        S_DECODE: begin
          a       <= rf[rs_idx];
          b       <= rf[rt_idx];
          alu_out <= br_tgt;
          if (dec.j) pc <= jt32[ADDR_W-1:0];
        end
        S_EXEC: begin
          if (dec.beq) begin
            if (a == b) pc <= alu_out[ADDR_W-1:0];
          end else alu_out <= alu_res;
        end
        S_MEM: if (mem_accept && dec.lw) mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign wb_idx  = dec.r_alu ? rd[RW-1:0] : rt_idx;
  assign wb_data = dec.lw ? mdr : alu_out;

  // r0 is never written, so it reads zero without a read-side mux.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (state == S_WB && wb_idx != '0) begin
      rf[wb_idx] <= wb_data;
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, ir[10:6], rs, rt, rd, alu_out};

endmodule
